// File: rtl/wdt_param.sv
// Parametrised watchdog timer on the peripheral bus: programmable period, lock,
// keyed kick, pre-timeout warning and a stretched reset request.
module wdt_param #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 249999999,
    parameter int unsigned DEFAULT_PRE    = 0,
    parameter int unsigned RST_PULSE      = 16,
    parameter logic [15:0] KICK_KEY       = 16'hA5C3,
    parameter bit          AUTO_START     = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        resetrequest
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_CONTROL = 3'd1;
    localparam logic [2:0] A_PER_LO  = 3'd2;
    localparam logic [2:0] A_PER_HI  = 3'd3;
    localparam logic [2:0] A_KICK    = 3'd4;
    localparam logic [2:0] A_SNAP_LO = 3'd5;
    localparam logic [2:0] A_SNAP_HI = 3'd6;
    localparam logic [2:0] A_PRE     = 3'd7;

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [15:0]      DEF_PRE    = 16'(DEFAULT_PRE);
    localparam int unsigned      RW         = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [RW-1:0]    PULSE_LD   = RW'(RST_PULSE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_snap;
    logic [15:0]      r_pre_th;
    logic             r_run;
    logic             r_to;
    logic             r_pre;
    logic             r_lock;
    logic             r_ito;
    logic             r_ipre;
    logic             r_irq;
    logic             r_rstreq;
    logic [RW-1:0]    r_pulse_cnt;
    logic [15:0]      r_rd;

    logic             w_wr;
    logic             w_ctl_wr;
    logic             w_st_wr;
    logic             w_per_wr;
    logic             w_kick_ok;
    logic             w_kick_bad;
    logic             w_tmo;
    logic             w_pre_hit;
    logic [31:0]      w_p32;
    logic [31:0]      w_snap32;
    logic [CNT_W-1:0] w_period_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_run_nx;
    logic             w_to_nx;
    logic             w_pre_nx;
    logic             w_ito_nx;
    logic             w_ipre_nx;
    logic             w_lock_nx;
    logic [15:0]      w_rd_nx;

    always_comb begin
        w_wr       = chipselect && !write_n;
        w_ctl_wr   = w_wr && (address == A_CONTROL);
        w_st_wr    = w_wr && (address == A_STATUS);
        w_kick_ok  = w_wr && (address == A_KICK) && r_run && (writedata == KICK_KEY);
        w_kick_bad = w_wr && (address == A_KICK) && r_run && (writedata != KICK_KEY);
        // A correct key in the zero cycle both reloads and cancels that cycle's timeout
        w_tmo      = (r_run && (r_cnt == '0) && !w_kick_ok) || w_kick_bad;
        w_pre_hit  = r_run && (r_pre_th != '0) && (r_cnt == CNT_W'(r_pre_th));

        w_per_wr = w_wr && !r_lock && ((address == A_PER_LO) || (address == A_PER_HI));
        w_p32    = 32'(r_period);
        if (w_per_wr) begin
            if (address == A_PER_LO) w_p32[15:0]  = writedata;
            else                     w_p32[31:16] = writedata;
        end
        w_period_nx = w_p32[CNT_W-1:0];

        w_cnt_nx = r_cnt;
        if (w_per_wr)                               w_cnt_nx = w_period_nx;
        else if (w_kick_ok || (r_run && r_cnt == '0)) w_cnt_nx = r_period;
        else if (r_run)                             w_cnt_nx = r_cnt - CNT_W'(1);

        w_ito_nx  = w_ctl_wr ? writedata[0] : r_ito;
        w_ipre_nx = w_ctl_wr ? writedata[1] : r_ipre;
        w_lock_nx = r_lock || (w_ctl_wr && writedata[4]);

        // STOP overrides START; a held or newly written LOCK overrides both
        w_run_nx = r_run;
        if (w_ctl_wr && writedata[2])            w_run_nx = 1'b1;
        if (w_ctl_wr && writedata[3] && !r_lock) w_run_nx = 1'b0;
        if (w_lock_nx)                           w_run_nx = 1'b1;

        w_to_nx  = w_tmo     || (r_to  && !(w_st_wr && writedata[0]));
        w_pre_nx = w_pre_hit || (r_pre && !(w_st_wr && writedata[2]));

        w_snap32 = 32'(r_snap);
        case (address)
            A_STATUS:  w_rd_nx = {12'd0, r_lock, r_pre, r_run, r_to};
            A_CONTROL: w_rd_nx = {14'd0, r_ipre, r_ito};
            A_PER_LO:  w_rd_nx = w_p32[15:0];
            A_PER_HI:  w_rd_nx = w_p32[31:16];
            A_SNAP_LO: w_rd_nx = w_snap32[15:0];
            A_SNAP_HI: w_rd_nx = w_snap32[31:16];
            A_PRE:     w_rd_nx = r_pre_th;
            default:   w_rd_nx = '0;
        endcase
        if (w_per_wr) w_rd_nx = w_rd_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= DEF_PERIOD;
            r_period    <= DEF_PERIOD;
            r_snap      <= '0;
            r_pre_th    <= DEF_PRE;
            r_run       <= AUTO_START;
            r_to        <= 1'b0;
            r_pre       <= 1'b0;
            r_lock      <= 1'b0;
            r_ito       <= 1'b0;
            r_ipre      <= 1'b0;
            r_irq       <= 1'b0;
            r_rstreq    <= 1'b0;
            r_pulse_cnt <= '0;
            r_rd        <= '0;
        end else begin
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_run    <= w_run_nx;
            r_to     <= w_to_nx;
            r_pre    <= w_pre_nx;
            r_lock   <= w_lock_nx;
            r_ito    <= w_ito_nx;
            r_ipre   <= w_ipre_nx;
            r_irq    <= (w_to_nx && w_ito_nx) || (w_pre_nx && w_ipre_nx);
            r_rd     <= w_rd_nx;
            if (w_wr && (address == A_SNAP_LO)) r_snap <= r_cnt;
            if (w_wr && !r_lock && (address == A_PRE)) r_pre_th <= writedata;
            if (w_tmo) begin
                r_rstreq    <= 1'b1;
                r_pulse_cnt <= PULSE_LD;
            end else if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - RW'(1);
            end else begin
                r_rstreq <= 1'b0;
            end
        end
    end

    assign readdata     = r_rd;
    assign irq          = r_irq;
    assign resetrequest = r_rstreq;

endmodule
